// File: rtl/qam_map_pkg.sv
// Shared definitions for the QPSK/16-QAM/64-QAM upsampling mapper:
// mode encodings, emitter state type, per-order scale factor and Gray decode.
package qam_map_pkg;

  localparam logic [1:0] MODE_QPSK = 2'd0;
  localparam logic [1:0] MODE_16   = 2'd1;
  localparam logic [1:0] MODE_64   = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Wide enough to evaluate scale factors for any practical OUT_W.
  localparam int SCALE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1
  } emit_state_t;

  // S_L = floor((2^(out_w-1)-1)/(levels-1)): largest step that keeps the
  // outermost level inside the signed output range.
  function automatic logic [SCALE_W-1:0] scale_for(input int out_w, input int levels);
    logic [SCALE_W-1:0] peak;
    peak = (SCALE_W'(1) << (out_w - 1)) - SCALE_W'(1);
    return peak / SCALE_W'(levels - 1);
  endfunction

  // Gray code to binary index; narrower fields are zero-extended by the caller.
  function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/qam_sym_fifo.sv
// Small synchronous FIFO holding {mode, in_bits} entries. The head entry is
// visible on o_rdata whenever o_empty is low (show-ahead read).
module qam_sym_fifo
  import qam_map_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr,
  input  logic [7:0] i_wdata,
  input  logic       i_rd,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_wr;
  logic        w_do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (rst_n && w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/qam_upsampling_mapper.sv
// Run-time selectable QPSK/16-QAM/64-QAM Gray mapper with input FIFO and
// OSR-fold upsampling. One registered I/Q sample per clock while symbols are
// queued; phases 1..OSR-1 are zero-stuffed or held depending on HOLD_MODE.
module qam_upsampling_mapper
  import qam_map_pkg::*;
#(
  parameter int OUT_W      = 32,
  parameter int OSR        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [5:0]              in_bits,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    out_valid,
  output logic                    out_sym_start,
  output logic                    underrun,
  output logic                    err_mode,
  output logic [1:0]              dbg_state
);

  localparam int PW   = OUT_W + 4;
  localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

  localparam logic signed [PW-1:0] S_QPSK = PW'(scale_for(OUT_W, 2));
  localparam logic signed [PW-1:0] S_16   = PW'(scale_for(OUT_W, 4));
  localparam logic signed [PW-1:0] S_64   = PW'(scale_for(OUT_W, 8));

  // Input handshake: a transfer happens on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on FIFO fullness (never on
  // in_valid or on a same-cycle pop) and is held low during reset.
  logic       w_full;
  logic       w_empty;
  logic       w_wr;
  logic       w_pop;
  logic [7:0] w_head;

  assign in_ready = rst_n && !w_full;
  assign w_wr     = in_valid && in_ready;

  qam_sym_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_wr),
    .i_wdata ({mode, in_bits}),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ---------------------------------------------------------------- mapper
  logic [1:0]              w_head_mode;
  logic [5:0]              w_head_bits;
  logic [2:0]              w_gi, w_gq;
  logic [2:0]              w_ki, w_kq;
  logic signed [4:0]       w_lm1;
  logic signed [4:0]       w_lvl_i, w_lvl_q;
  logic signed [PW-1:0]    w_lvl_ext_i, w_lvl_ext_q;
  logic signed [PW-1:0]    w_s;
  logic                    w_rsvd;
  logic signed [OUT_W-1:0] w_map_i, w_map_q;

  assign w_head_mode = w_head[7:6];
  assign w_head_bits = w_head[5:0];

  // Split the head entry into axis fields, Gray-decode and scale to levels.
  always_comb begin
    w_gi   = '0;
    w_gq   = '0;
    w_lm1  = 5'sd1;
    w_s    = S_QPSK;
    w_rsvd = 1'b0;
    case (w_head_mode)
      MODE_QPSK: begin
        w_gi = {2'b00, w_head_bits[1]};
        w_gq = {2'b00, w_head_bits[0]};
      end
      MODE_16: begin
        w_gi  = {1'b0, w_head_bits[3:2]};
        w_gq  = {1'b0, w_head_bits[1:0]};
        w_lm1 = 5'sd3;
        w_s   = S_16;
      end
      MODE_64: begin
        w_gi  = w_head_bits[5:3];
        w_gq  = w_head_bits[2:0];
        w_lm1 = 5'sd7;
        w_s   = S_64;
      end
      default: w_rsvd = 1'b1;
    endcase
    w_ki        = gray_to_bin(w_gi);
    w_kq        = gray_to_bin(w_gq);
    // level = 2k - (L-1), symmetric around zero
    w_lvl_i     = $signed({1'b0, w_ki, 1'b0}) - w_lm1;
    w_lvl_q     = $signed({1'b0, w_kq, 1'b0}) - w_lm1;
    w_lvl_ext_i = $signed({{(PW-5){w_lvl_i[4]}}, w_lvl_i});
    w_lvl_ext_q = $signed({{(PW-5){w_lvl_q[4]}}, w_lvl_q});
    // Peak |level*S| never exceeds 2^(OUT_W-1)-1, so truncation is lossless.
    w_map_i     = w_rsvd ? '0 : OUT_W'(w_lvl_ext_i * w_s);
    w_map_q     = w_rsvd ? '0 : OUT_W'(w_lvl_ext_q * w_s);
  end

  // --------------------------------------------------------------- emitter
  emit_state_t             r_state, w_state_nxt;
  logic [PH_W-1:0]         r_phase, w_phase_nxt;
  logic signed [OUT_W-1:0] r_sym_i, r_sym_q, w_sym_i_nxt, w_sym_q_nxt;
  logic signed [OUT_W-1:0] r_out_i, r_out_q, w_out_i_nxt, w_out_q_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_start, w_start_nxt;
  logic                    r_underrun, w_underrun_nxt;
  logic                    r_err, w_err_nxt;

  // Next-state and next-output logic; a pop always starts a fresh phase 0.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_sym_i_nxt    = r_sym_i;
    w_sym_q_nxt    = r_sym_q;
    w_out_i_nxt    = '0;
    w_out_q_nxt    = '0;
    w_valid_nxt    = 1'b0;
    w_start_nxt    = 1'b0;
    w_underrun_nxt = 1'b0;
    w_err_nxt      = r_err;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_pop = 1'b1;
      end
      ST_EMIT: begin
        if (r_phase == PH_LAST) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_phase_nxt    = '0;
            w_underrun_nxt = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase + PH_W'(1);
          w_valid_nxt = 1'b1;
          w_out_i_nxt = (HOLD_MODE != 0) ? r_sym_i : '0;
          w_out_q_nxt = (HOLD_MODE != 0) ? r_sym_q : '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_pop) begin
      w_state_nxt = ST_EMIT;
      w_phase_nxt = '0;
      w_sym_i_nxt = w_map_i;
      w_sym_q_nxt = w_map_q;
      w_out_i_nxt = w_map_i;
      w_out_q_nxt = w_map_q;
      w_valid_nxt = 1'b1;
      w_start_nxt = 1'b1;
      if (w_rsvd) w_err_nxt = 1'b1;
    end
  end

  // State and output registers; reset abandons any symbol in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_sym_i    <= '0;
      r_sym_q    <= '0;
      r_out_i    <= '0;
      r_out_q    <= '0;
      r_valid    <= 1'b0;
      r_start    <= 1'b0;
      r_underrun <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_sym_i    <= w_sym_i_nxt;
      r_sym_q    <= w_sym_q_nxt;
      r_out_i    <= w_out_i_nxt;
      r_out_q    <= w_out_q_nxt;
      r_valid    <= w_valid_nxt;
      r_start    <= w_start_nxt;
      r_underrun <= w_underrun_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign out_i         = r_out_i;
  assign out_q         = r_out_q;
  assign out_valid     = r_valid;
  assign out_sym_start = r_start;
  assign underrun      = r_underrun;
  assign err_mode      = r_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_qam_upsampling_mapper.sv
// Bench for qam_upsampling_mapper: one zero-stuffing instance (dut0) and one
// hold-mode instance (dut1), both OUT_W=32, OSR=4, FIFO_DEPTH=4.
module tb_qam_upsampling_mapper;

  localparam int OSR = 4;

  // ------------------------------------------------ clock and reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]  mode0, mode1;
  logic [5:0]  bits0, bits1;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic [31:0] oi0, oq0, oi1, oq1;
  logic        ov0, ov1, ss0, ss1, ur0, ur1, em0, em1;
  logic [1:0]  st0, st1;

  qam_upsampling_mapper #(.OUT_W(32), .OSR(OSR), .FIFO_DEPTH(4), .HOLD_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode0), .in_bits(bits0), .in_valid(valid0),
    .in_ready(ready0), .out_i(oi0), .out_q(oq0), .out_valid(ov0),
    .out_sym_start(ss0), .underrun(ur0), .err_mode(em0), .dbg_state(st0)
  );

  qam_upsampling_mapper #(.OUT_W(32), .OSR(OSR), .FIFO_DEPTH(4), .HOLD_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode1), .in_bits(bits1), .in_valid(valid1),
    .in_ready(ready1), .out_i(oi1), .out_q(oq1), .out_valid(ov1),
    .out_sym_start(ss1), .underrun(ur1), .err_mode(em1), .dbg_state(st1)
  );

  // ------------------------------------------------------------ scoreboard
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  int   nv0   = 0;
  int   first0 = -1;
  int   last0  = -1;
  logic saw_full = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Index whose Gray code equals field (forward encode search).
  function automatic int gray_index(input int field, input int levels);
    for (int j = 0; j < levels; j++) begin
      if ((j ^ (j >> 1)) == field) return j;
    end
    return 0;
  endfunction

  function automatic logic [31:0] axis_value(input logic [1:0] m, input int field);
    longint s;
    longint lvl;
    int     levels;
    case (m)
      2'd0: begin levels = 2; s = 64'd2147483647; end
      2'd1: begin levels = 4; s = 64'd715827882;  end
      2'd2: begin levels = 8; s = 64'd306783378;  end
      default: return 32'd0;
    endcase
    lvl = longint'(2 * gray_index(field, levels) - (levels - 1));
    return 32'(lvl * s);
  endfunction

  function automatic void expect_sym(input int d, input logic [1:0] m, input logic [5:0] b);
    int          fi, fq;
    logic [31:0] vi, vq;
    logic [64:0] e;
    case (m)
      2'd0:    begin fi = int'(b[1]);   fq = int'(b[0]);   end
      2'd1:    begin fi = int'(b[3:2]); fq = int'(b[1:0]); end
      2'd2:    begin fi = int'(b[5:3]); fq = int'(b[2:0]); end
      default: begin fi = 0;            fq = 0;            end
    endcase
    vi = axis_value(m, fi);
    vq = axis_value(m, fq);
    for (int p = 0; p < OSR; p++) begin
      if (p == 0)      e = {1'b1, vi, vq};
      else if (d == 1) e = {1'b0, vi, vq};
      else             e = '0;
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endfunction

  // Output monitor: every valid sample is popped from the expected queue.
  always @(negedge clk) begin : mon
    logic [64:0] e;
    ncyc++;
    if (ov0) begin
      if (first0 < 0) first0 = ncyc;
      last0 = ncyc;
      nv0++;
      if (exp_q0.size() == 0) begin
        check("dut0_extra_sample", {63'd0, ov0}, 64'd0);
      end else begin
        e = exp_q0.pop_front();
        check("dut0_sym_start", {63'd0, ss0}, {63'd0, e[64]});
        check("dut0_i", {32'd0, oi0}, {32'd0, e[63:32]});
        check("dut0_q", {32'd0, oq0}, {32'd0, e[31:0]});
      end
    end else begin
      check("dut0_idle_i", {32'd0, oi0}, 64'd0);
      check("dut0_idle_q", {32'd0, oq0}, 64'd0);
      check("dut0_idle_start", {63'd0, ss0}, 64'd0);
    end
    if (ov1) begin
      if (exp_q1.size() == 0) begin
        check("dut1_extra_sample", {63'd0, ov1}, 64'd0);
      end else begin
        e = exp_q1.pop_front();
        check("dut1_sym_start", {63'd0, ss1}, {63'd0, e[64]});
        check("dut1_i", {32'd0, oi1}, {32'd0, e[63:32]});
        check("dut1_q", {32'd0, oq1}, {32'd0, e[31:0]});
      end
    end else begin
      check("dut1_idle_i", {32'd0, oi1}, 64'd0);
      check("dut1_idle_q", {32'd0, oq1}, 64'd0);
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic push(input int d, input logic [1:0] m, input logic [5:0] b);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      if (d == 0) begin valid0 = 1'b1; mode0 = m; bits0 = b; acc = ready0; end
      else        begin valid1 = 1'b1; mode1 = m; bits1 = b; acc = ready1; end
      if (!acc) saw_full = 1'b1;
      @(posedge clk);
      tries++;
    end
    #1;
    if (d == 0) valid0 = 1'b0;
    else        valid1 = 1'b0;
    check("push_accepted", {63'd0, acc}, 64'd1);
    if (acc) expect_sym(d, m, b);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (!(exp_q0.size() == 0 && exp_q1.size() == 0 && !ov0 && !ov1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < 400), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_span();
    nv0    = 0;
    first0 = -1;
    last0  = -1;
  endtask

  // One symbol into an idle emitter: 1-cycle latency, 4 samples, underrun.
  task automatic single_symbol(input logic [5:0] b);
    push(0, 2'd0, b);
    @(negedge clk);
    check("single_latency_gap", {63'd0, ov0}, 64'd0);
    @(negedge clk);
    check("single_first_valid", {63'd0, ov0}, 64'd1);
    check("single_first_start", {63'd0, ss0}, 64'd1);
    repeat (OSR - 1) begin
      @(negedge clk);
      check("single_valid", {63'd0, ov0}, 64'd1);
      check("single_no_underrun", {63'd0, ur0}, 64'd0);
    end
    @(negedge clk);
    check("single_underrun", {63'd0, ur0}, 64'd1);
    check("single_ends", {63'd0, ov0}, 64'd0);
    @(negedge clk);
    check("single_underrun_pulse", {63'd0, ur0}, 64'd0);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    int n;
    rst_n  = 1'b0;
    valid0 = 1'b0; mode0 = 2'd0; bits0 = 6'd0;
    valid1 = 1'b0; mode1 = 2'd0; bits1 = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, ov0}, 64'd0);
    check("rst_i", {32'd0, oi0}, 64'd0);
    check("rst_ready_low", {63'd0, ready0}, 64'd0);
    check("rst_err", {63'd0, em0}, 64'd0);
    check("rst_underrun", {63'd0, ur0}, 64'd0);
    check("rst_state", {62'd0, st0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {63'd0, ready0}, 64'd1);

    // QPSK 0..3 back-to-back: gapless 16 samples.
    clear_span();
    for (int s = 0; s < 4; s++) push(0, 2'd0, 6'(s));
    wait_drain("qpsk_drain");
    check("qpsk_count", 64'(nv0), 64'd16);
    check("qpsk_gapless", 64'(last0 - first0 + 1), 64'd16);

    // 16-QAM sweep of all 16 codes.
    clear_span();
    for (int s = 0; s < 16; s++) push(0, 2'd1, 6'(s));
    wait_drain("qam16_drain");
    check("qam16_count", 64'(nv0), 64'd64);
    check("qam16_gapless", 64'(last0 - first0 + 1), 64'd64);

    // 64-QAM hold mode: corner point held for all phases.
    push(1, 2'd2, 6'b100000);
    n = 0;
    while (!ov1 && n < 10) begin @(negedge clk); n++; end
    for (int p = 0; p < OSR; p++) begin
      check("hold64_valid", {63'd0, ov1}, 64'd1);
      check("hold64_i", {32'd0, oi1}, {32'd0, 32'd2147483646});
      check("hold64_q", {32'd0, oq1}, {32'd0, 32'h8000_0002});
      if (p < OSR - 1) @(negedge clk);
    end
    wait_drain("hold64_drain");

    // Back-pressure: six pushes in consecutive cycles overfill the FIFO.
    clear_span();
    saw_full = 1'b0;
    for (int s = 0; s < 6; s++) push(0, 2'd1, 6'($urandom_range(0, 15)));
    wait_drain("bp_drain");
    check("bp_ready_dropped", {63'd0, saw_full}, 64'd1);
    check("bp_count", 64'(nv0), 64'd24);

    // Single symbols separated by silence.
    single_symbol(6'd2);
    repeat (3) @(negedge clk);
    single_symbol(6'd1);
    wait_drain("single_drain");

    // Mixed modes per entry, both instances.
    for (int s = 0; s < 10; s++) begin
      push(0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 63)));
      push(1, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 63)));
    end
    wait_drain("mixed_drain");
    check("err_clear_normal", {63'd0, em0}, 64'd0);

    // Reserved entry, then reset in the middle of its emission.
    push(0, 2'd3, 6'($urandom_range(0, 63)));
    n = 0;
    while (!ov0 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    check("rsvd_mid_emit", {63'd0, ov0}, 64'd1);
    check("rsvd_err", {63'd0, em0}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    check("mid_rst_valid", {63'd0, ov0}, 64'd0);
    check("mid_rst_i", {32'd0, oi0}, 64'd0);
    check("mid_rst_q", {32'd0, oq0}, 64'd0);
    check("mid_rst_err", {63'd0, em0}, 64'd0);
    check("mid_rst_ready", {63'd0, ready0}, 64'd0);
    check("mid_rst_state", {62'd0, st0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {63'd0, ready0}, 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_fifo_empty", {63'd0, ov0}, 64'd0);
    end
    single_symbol(6'd3);
    wait_drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
